// File: rtl/s2p_pkg.sv
// s2p_pkg: definitions shared by the s2p lane-alignment controller.
//   lane_state_e : per-lane alignment FSM state (HUNT, CHECK, LOCKED)
//   CNT_W        : width of the per-lane miss/COM/frame/error counters
//   DEF_COM      : default alignment (comma) symbol
//   DEF_LANES    : default number of s2p lanes
package s2p_pkg;

  localparam int unsigned CNT_W     = 4;
  localparam logic [7:0]  DEF_COM   = 8'hBC;
  localparam int unsigned DEF_LANES = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lane_state_e;

endpackage

// File: rtl/s2p_lane_sync.sv
// s2p_lane_sync: alignment FSM for one s2p lane.
// Hunts for COM, asks the s2p for a one-bit window slip after SLIP_AFTER
// non-COM bytes, locks after LOCK_COUNT consecutive COMs and then expects COM
// every FRAME_LEN bytes, dropping back to HUNT after ERR_MAX missing COMs.
// Optional feature macro: S2P_SYNC_STATS_EN (8-bit saturating loss counter).
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   enb_i             block enable; low forces HUNT
//   byte_valid_i      one strobe per received byte period
//   lane_byte_i[7:0]  this lane's recovered byte
//   bit_slip_o        one-cycle slip request
//   lane_sync_o       lane is LOCKED
//   loss_cnt_o[7:0]   LOCKED->HUNT transition count (0 when not built)
module s2p_lane_sync
  import s2p_pkg::*;
#(
  parameter logic [7:0]  COM        = DEF_COM,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned SLIP_AFTER = 8,
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned ERR_MAX    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enb_i,
  input  logic       byte_valid_i,
  input  logic [7:0] lane_byte_i,
  output logic       bit_slip_o,
  output logic       lane_sync_o,
  output logic [7:0] loss_cnt_o
);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] com_q, com_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             slip_q, slip_d;
  logic             sync_q, sync_d;
  logic             lost;
  logic             is_com;

  assign is_com = (lane_byte_i == COM);

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    com_d   = com_q;
    fidx_d  = fidx_q;
    err_d   = err_q;
    slip_d  = 1'b0;
    lost    = 1'b0;
    if (!enb_i) begin
      state_d = HUNT;
      miss_d  = '0;
      com_d   = '0;
      fidx_d  = '0;
      err_d   = '0;
    end else if (byte_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (is_com) begin
            state_d = CHECK;
            com_d   = CNT_W'(1);
            miss_d  = '0;
          end else if (miss_q + CNT_W'(1) == CNT_W'(SLIP_AFTER)) begin
            slip_d = 1'b1;
            miss_d = '0;
          end else begin
            miss_d = miss_q + CNT_W'(1);
          end
        end
        CHECK: begin
          if (!is_com) begin
            // The breaking byte already counts as the first miss.
            state_d = HUNT;
            miss_d  = CNT_W'(1);
            com_d   = '0;
          end else if (com_q + CNT_W'(1) == CNT_W'(LOCK_COUNT)) begin
            // The locking COM sits at frame index 0, so the next byte is index 1.
            state_d = LOCKED;
            com_d   = '0;
            fidx_d  = CNT_W'(1);
            err_d   = '0;
          end else begin
            com_d = com_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          fidx_d = (fidx_q == CNT_W'(FRAME_LEN - 1)) ? '0 : fidx_q + CNT_W'(1);
          if (fidx_q == '0) begin
            if (is_com) begin
              err_d = '0;
            end else if (err_q + CNT_W'(1) == CNT_W'(ERR_MAX)) begin
              state_d = HUNT;
              miss_d  = '0;
              com_d   = '0;
              fidx_d  = '0;
              err_d   = '0;
              lost    = 1'b1;
            end else begin
              err_d = err_q + CNT_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    sync_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      miss_q  <= '0;
      com_q   <= '0;
      fidx_q  <= '0;
      err_q   <= '0;
      slip_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      com_q   <= com_d;
      fidx_q  <= fidx_d;
      err_q   <= err_d;
      slip_q  <= slip_d;
      sync_q  <= sync_d;
    end
  end

  assign bit_slip_o  = slip_q;
  assign lane_sync_o = sync_q;

`ifdef S2P_SYNC_STATS_EN
  logic [7:0] loss_q, loss_d;

  // Saturates at 8'hFF; ENB deliberately leaves it untouched.
  always_comb begin
    loss_d = loss_q;
    if (lost && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      loss_q <= 8'h00;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_cnt_o = loss_q;
`else
  logic unused_lost;
  assign unused_lost = lost;
  assign loss_cnt_o  = 8'h00;
`endif

endmodule

// File: rtl/s2p_sync_ctrl.sv
// s2p_sync_ctrl: lane-alignment controller after the 4-lane s2p converter.
// One s2p_lane_sync per lane; this level forms all_sync and registers the
// aligned parallel bytes for the downstream byte logic.
// Optional feature macro: S2P_SYNC_STATS_EN (per-lane sync-loss counters).
// Ports:
//   CLK, reset          clock, asynchronous active-high reset
//   ENB                 block enable; low forces every lane to HUNT
//   byte_valid          one strobe per received byte period
//   lane_data[8L-1:0]   parallel bytes, lane i at [8i+7:8i]
//   bit_slip[L-1:0]     per-lane one-cycle slip requests
//   lane_sync[L-1:0]    per-lane locked
//   all_sync            every lane locked
//   data_out[8L-1:0]    registered lane_data, zero unless all_sync
//   valid_out           data_out valid
//   loss_cnt[8L-1:0]    per-lane sync-loss counters (0 when not built)
module s2p_sync_ctrl
  import s2p_pkg::*;
#(
  parameter int unsigned LANES      = DEF_LANES,
  parameter logic [7:0]  COM        = DEF_COM,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned SLIP_AFTER = 8,
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned ERR_MAX    = 3
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 ENB,
  input  logic                 byte_valid,
  input  logic [8*LANES-1:0]   lane_data,
  output logic [LANES-1:0]     bit_slip,
  output logic [LANES-1:0]     lane_sync,
  output logic                 all_sync,
  output logic [8*LANES-1:0]   data_out,
  output logic                 valid_out,
  output logic [8*LANES-1:0]   loss_cnt
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    s2p_lane_sync #(
      .COM        (COM),
      .LOCK_COUNT (LOCK_COUNT),
      .SLIP_AFTER (SLIP_AFTER),
      .FRAME_LEN  (FRAME_LEN),
      .ERR_MAX    (ERR_MAX)
    ) u_lane (
      .clk_i        (CLK),
      .rst_i        (reset),
      .enb_i        (ENB),
      .byte_valid_i (byte_valid),
      .lane_byte_i  (lane_data[8*i +: 8]),
      .bit_slip_o   (bit_slip[i]),
      .lane_sync_o  (lane_sync[i]),
      .loss_cnt_o   (loss_cnt[8*i +: 8])
    );
  end

  assign all_sync = &lane_sync;

  logic [8*LANES-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (!ENB || !all_sync) begin
      data_d = '0;
    end else if (byte_valid) begin
      data_d  = lane_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Gate with the registered all_sync so the outputs read zero from the very
  // cycle sync is lost, even if the byte on the losing strobe was captured.
  assign data_out  = data_q & {(8*LANES){all_sync}};
  assign valid_out = valid_q & all_sync;

endmodule

// File: tb/tb_s2p_sync_ctrl.sv
// tb_s2p_sync_ctrl: directed plus randomized checks of s2p_sync_ctrl against
// a behavioural lane-alignment model kept in this bench.
module tb_s2p_sync_ctrl;

  localparam int         LANES      = 4;
  localparam logic [7:0] COM        = 8'hBC;
  localparam int         LOCK_COUNT = 4;
  localparam int         SLIP_AFTER = 8;
  localparam int         FRAME_LEN  = 4;
  localparam int         ERR_MAX    = 3;
  localparam logic [31:0] ALL_COM   = {4{8'hBC}};

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        ENB = 1'b0;
  logic        byte_valid = 1'b0;
  logic [31:0] lane_data = '0;
  logic [3:0]  bit_slip;
  logic [3:0]  lane_sync;
  logic        all_sync;
  logic [31:0] data_out;
  logic        valid_out;
  logic [31:0] loss_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  s2p_sync_ctrl #(
    .LANES      (LANES),
    .COM        (COM),
    .LOCK_COUNT (LOCK_COUNT),
    .SLIP_AFTER (SLIP_AFTER),
    .FRAME_LEN  (FRAME_LEN),
    .ERR_MAX    (ERR_MAX)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .ENB        (ENB),
    .byte_valid (byte_valid),
    .lane_data  (lane_data),
    .bit_slip   (bit_slip),
    .lane_sync  (lane_sync),
    .all_sync   (all_sync),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .loss_cnt   (loss_cnt)
  );

  // Model: mode 0 = hunting, 1 = collecting COMs, 2 = locked.
  int          m_mode [LANES];
  int          m_run  [LANES];  // hunting: non-COMs since last slip; collecting: COMs seen
  int          m_since[LANES];  // bytes received since lock
  int          m_bad  [LANES];  // consecutive missing frame COMs
  int          m_loss [LANES];
  bit          m_slip [LANES];
  logic [31:0] m_dq;
  bit          m_vq;

  function automatic bit m_all();
    bit a = 1'b1;
    for (int i = 0; i < LANES; i++) a &= (m_mode[i] == 2);
    return a;
  endfunction

  task automatic model_edge(input bit rst, input bit enb, input bit bv, input logic [31:0] d);
    bit was_all;
    logic [7:0] b;
    if (rst || !enb) begin
      for (int i = 0; i < LANES; i++) begin
        m_mode[i] = 0; m_run[i] = 0; m_since[i] = 0; m_bad[i] = 0; m_slip[i] = 0;
        if (rst) m_loss[i] = 0;
      end
      m_dq = '0;
      m_vq = 1'b0;
      return;
    end
    was_all = m_all();
    m_vq = 1'b0;
    if (!was_all) m_dq = '0;
    else if (bv) begin
      m_dq = d;
      m_vq = 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      m_slip[i] = 1'b0;
      if (bv) begin
        b = d[8*i +: 8];
        case (m_mode[i])
          0: begin
            if (b == COM) begin
              m_mode[i] = 1; m_run[i] = 1;
            end else begin
              m_run[i]++;
              if (m_run[i] == SLIP_AFTER) begin
                m_slip[i] = 1'b1; m_run[i] = 0;
              end
            end
          end
          1: begin
            if (b == COM) begin
              m_run[i]++;
              if (m_run[i] == LOCK_COUNT) begin
                m_mode[i] = 2; m_since[i] = 0; m_bad[i] = 0; m_run[i] = 0;
              end
            end else begin
              m_mode[i] = 0; m_run[i] = 1;
            end
          end
          default: begin
            m_since[i]++;
            if (m_since[i] % FRAME_LEN == 0) begin
              if (b == COM) m_bad[i] = 0;
              else begin
                m_bad[i]++;
                if (m_bad[i] == ERR_MAX) begin
                  m_mode[i] = 0; m_run[i] = 0; m_bad[i] = 0;
                  if (m_loss[i] < 255) m_loss[i]++;
                end
              end
            end
          end
        endcase
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0]  es, ek;
    logic [31:0] el;
    bit          ea;
    for (int i = 0; i < LANES; i++) begin
      es[i] = (m_mode[i] == 2);
      ek[i] = m_slip[i];
`ifdef S2P_SYNC_STATS_EN
      el[8*i +: 8] = 8'(m_loss[i]);
`else
      el[8*i +: 8] = 8'h00;
`endif
    end
    ea = &es;
    check_eq("lane_sync", 64'(lane_sync), 64'(es));
    check_eq("bit_slip", 64'(bit_slip), 64'(ek));
    check_eq("all_sync", 64'(all_sync), 64'(ea));
    check_eq("data_out", 64'(data_out), ea ? 64'(m_dq) : 64'd0);
    check_eq("valid_out", 64'(valid_out), 64'(m_vq && ea));
    check_eq("loss_cnt", 64'(loss_cnt), 64'(el));
  endtask

  task automatic step(input bit bv, input logic [31:0] d);
    byte_valid = bv;
    lane_data  = d;
    @(posedge CLK);
    model_edge(1'b0, ENB, bv, d);
    #1;
    check_all();
  endtask

  function automatic logic [31:0] set_lane(input logic [31:0] base, input int lane,
                                           input logic [7:0] b);
    logic [31:0] r = base;
    r[8*lane +: 8] = b;
    return r;
  endfunction

  // Asserted and checked between clock edges, then released before the next edge.
  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    model_edge(1'b1, 1'b0, 1'b0, '0);
    #1 check_all();
    #1 reset = 1'b0;
  endtask

  task automatic enb_clear();
    ENB = 1'b0;
    step(1'b1, ALL_COM);
    ENB = 1'b1;
  endtask

  initial begin
    int slips;
    logic [31:0] d;

    // Reset
    repeat (2) @(posedge CLK);
    model_edge(1'b1, 1'b0, 1'b0, '0);
    #1 check_all();
    reset = 1'b0;

    // Lock, then first qualified word
    ENB = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, ALL_COM);
    check_eq("lock_sync", 64'(lane_sync), 64'hF);
    step(1'b0, '0);
    step(1'b1, 32'h11223344);
    check_eq("first_data", 64'(data_out), 64'h11223344);
    check_eq("first_valid", 64'(valid_out), 64'd1);
    step(1'b0, '0);

    // Slip on lane 2
    enb_clear();
    slips = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, set_lane(ALL_COM, 2, 8'h5E));
      if (k == 8) check_eq("slip_at_8", 64'(bit_slip), 64'b0100);
      if (bit_slip[2]) slips++;
      step(1'b0, '0);
      if (bit_slip[2]) slips++;
    end
    check_eq("slip_pulses", 64'(slips), 64'd2);
    check_eq("slip_data_zero", 64'(data_out), 64'd0);

    // Broken CHECK on lane 0
    enb_clear();
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, set_lane(ALL_COM, 0, (k == 3) ? 8'h00 : COM));
      if (k == 6) check_eq("broken_not_yet", 64'(lane_sync[0]), 64'd0);
    end
    check_eq("broken_relock", 64'(lane_sync[0]), 64'd1);

    // Loss on lane 1: three missing frame COMs
    enb_clear();
    for (int k = 0; k < 4; k++) step(1'b1, ALL_COM);
    for (int k = 1; k <= 12; k++) begin
      d = set_lane(ALL_COM, 1, (k % 4 == 0) ? 8'h00 : 8'($urandom));
      step(1'b1, d);
    end
    check_eq("loss_sync1", 64'(lane_sync[1]), 64'd0);
    check_eq("loss_all", 64'(all_sync), 64'd0);
    check_eq("loss_valid", 64'(valid_out), 64'd0);
`ifdef S2P_SYNC_STATS_EN
    check_eq("loss_cnt1", 64'(loss_cnt[15:8]), 64'h01);
`endif
    // Relock lane 1, then two misses followed by a COM keeps lock
    for (int k = 0; k < 4; k++) step(1'b1, ALL_COM);
    for (int k = 1; k <= 12; k++) begin
      d = set_lane(ALL_COM, 1, (k == 4 || k == 8) ? 8'h00 :
                               (k == 12) ? COM : 8'($urandom));
      step(1'b1, d);
    end
    check_eq("two_miss_hold", 64'(lane_sync), 64'hF);

    // ENB drop while locked
    step(1'b1, 32'hA5A55A5A);
    enb_clear();
    check_eq("enb_sync", 64'(lane_sync), 64'd0);
    check_eq("enb_data", 64'(data_out), 64'd0);

    // Async reset while locked, then mid-CHECK; relock needs a full 4 COMs
    for (int k = 0; k < 4; k++) step(1'b1, ALL_COM);
    step(1'b1, 32'h0BADF00D);
    async_reset_pulse();
    for (int k = 0; k < 2; k++) step(1'b1, ALL_COM);
    async_reset_pulse();
    for (int k = 0; k < 3; k++) step(1'b1, ALL_COM);
    check_eq("relock_partial", 64'(lane_sync), 64'd0);
    step(1'b1, ALL_COM);
    check_eq("relock_full", 64'(lane_sync), 64'hF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ENB = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < LANES; i++)
        d[8*i +: 8] = ($urandom_range(0, 9) < 8) ? COM : 8'($urandom);
      step(1'($urandom_range(0, 1)), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/s2p_sync_ctrl.md
Name: s2p_sync_ctrl

Overview:
- Lane-alignment controller placed directly after the 4-lane serial-to-parallel converter. It watches each lane's recovered byte stream for the COM symbol and pulses per-lane bit-slip requests back to the s2p until alignment is found.
- It declares per-lane and global sync, and qualifies and forwards the aligned parallel bytes to the downstream byte logic.

Parameters:
- LANES, 4, number of s2p lanes.
- COM, 8'hBC, alignment/comma symbol.
- LOCK_COUNT, 4, consecutive COM bytes required to lock a lane (2..15).
- SLIP_AFTER, 8, non-COM bytes in HUNT before a bit-slip request (2..15).
- FRAME_LEN, 4, byte period at which COM must recur once locked (2..15).
- ERR_MAX, 3, consecutive missing COMs that drop a lane back to HUNT (1..7).

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ENB  in  1  block enable; low forces all lanes to HUNT.
- byte_valid  in  1  single-CLK strobe, one per received byte period (from the CLK_8 domain, pre-synchronised).
- lane_data  in  8*LANES  parallel bytes; lane i occupies bits [8i+7:8i].
- bit_slip  out  LANES  one-cycle pulse requesting lane i shift its s2p window by one bit.
- lane_sync  out  LANES  lane i locked.
- all_sync  out  1  all lanes locked.
- data_out  out  8*LANES  registered lane_data; zero unless all_sync.
- valid_out  out  1  data_out valid.
- loss_cnt  out  8*LANES  per-lane sync-loss counters (optional feature).

Behaviour:
- Reset (async): every lane goes to HUNT with all counters 0. All outputs are 0.
- ENB low: synchronously clears every lane to HUNT and zeroes all outputs except loss_cnt. byte_valid is ignored while ENB is low.
- Lane state and counters change only on cycles with byte_valid=1 and ENB=1. lane_sync, bit_slip, data_out and valid_out are registered.
- HUNT:
  - COM byte -> CHECK with com_cnt=1, miss_cnt=0.
  - Non-COM byte -> miss_cnt++.
  - When miss_cnt reaches SLIP_AFTER: bit_slip[i]=1 on the next cycle for exactly one cycle, and miss_cnt=0.
  - Back-to-back slips are therefore at least SLIP_AFTER bytes apart.
- CHECK:
  - COM byte -> com_cnt++. When com_cnt reaches LOCK_COUNT: go to LOCKED, frame_idx=1, err_cnt=0.
  - Non-COM byte -> HUNT with miss_cnt=1, com_cnt=0.
- LOCKED:
  - frame_idx counts modulo FRAME_LEN on each byte.
  - At frame_idx=0 the byte must equal COM. If it does, err_cnt=0; otherwise err_cnt++. Bytes at other indices are not checked.
  - When err_cnt reaches ERR_MAX: go to HUNT with counters 0, and loss_cnt[i]++.
- lane_sync[i] is 1 exactly when the lane is in LOCKED.
  - It rises one CLK after the LOCK_COUNT-th COM strobe.
  - It falls one CLK after the ERR_MAX-th miss strobe.
- all_sync = AND of lane_sync (combinational from the registered lane_sync).
- data_out / valid_out:
  - On a byte_valid cycle with all_sync=1: data_out <= lane_data, valid_out <= 1. Latency is 1 CLK.
  - Otherwise valid_out <= 0 and data_out holds its last value. data_out is forced to 0 while all_sync=0.
- Simultaneous events:
  - Lanes are fully independent. One lane's slip never affects another lane's counters.
  - A COM at frame_idx=0 on the same strobe as ENB falling: ENB wins.
- Reset asserted mid-operation overrides everything on the same edge.

Optional Feature:
- Macro: S2P_SYNC_STATS_EN.
- Defined: loss_cnt[i] is an 8-bit saturating counter (stops at 8'hFF) that increments on each LOCKED->HUNT transition. It is cleared only by reset; ENB does not clear it.
- Undefined: the counters are not built and loss_cnt is tied to 0. The port is always present so the bench is unchanged.

Decomposition:
- Shared package s2p_pkg holds:
  - lane FSM state typedef {HUNT, CHECK, LOCKED};
  - COM default 8'hBC;
  - counter-width constant CNT_W=4;
  - LANES default.
- Sub-module s2p_lane_sync: the per-lane FSM and its counters (miss_cnt, com_cnt, frame_idx, err_cnt, optional loss counter). It is instantiated LANES times.
- The top level holds only the all_sync AND and the data_out/valid_out register.

Test Plan:
- Lock: reset high 2 cycles, ENB=1, all lanes 8'hBC for 4 strobes -> lane_sync=4'hF one CLK after the 4th strobe, all_sync=1; the 5th strobe with lane_data=32'h11223344 -> data_out=32'h11223344, valid_out=1 next CLK.
- Slip: lane 2 fed 8'h5E for 8 strobes, other lanes 8'hBC -> bit_slip=4'b0100 for one cycle after the 8th strobe; after 16 non-COM strobes exactly two slip pulses; all_sync stays 0 and data_out=0.
- Broken CHECK: lane 0 sees BC, BC, 00, BC -> it returns to HUNT on the 3rd strobe; lock requires 4 further consecutive BC; lane_sync[0] rises after the 7th strobe total.
- Loss: locked, lane 1 frame-index-0 byte replaced by 8'h00 for 3 consecutive frames (FRAME_LEN=4) -> lane_sync[1] falls after the 12th strobe; all_sync=0; valid_out=0; with S2P_SYNC_STATS_EN, loss_cnt lane 1 = 8'h01. Only 2 misses followed by a COM -> stays locked.
- Control: ENB dropped while locked -> all outputs 0 next CLK, loss_cnt held. Async reset pulse mid-CHECK -> immediate outputs 0 without a clock edge; relock takes a full 4 COM strobes.
